mem_write_checker: RTL and testbench

Parametrised on-chip monitor for the ARM core's data-memory write port. It sits beside the `ARM` instance, sampling `MemWrite`/`ALUResult`/`WriteData` every cycle. It compares the write stream against a programmable list of up to `N_EXP` expected (address, data) writes, and raises sticky pass/fail with diagnostics. It replaces single-write, hand-coded success checks and is synthesizable, so the same check runs in simulation and on the board.

---
 rtl/mem_chk_pkg.sv | 18 +
 rtl/exp_table.sv | 52 +++++
 rtl/mem_write_checker.sv | 181 ++++++++++++++++++
 tb/tb_mem_write_checker.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_chk_pkg.sv
// Shared types for the memory-write checker: FSM state encoding and fail codes.
package mem_chk_pkg;

  localparam int unsigned FAIL_CODE_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_t;

  localparam logic [FAIL_CODE_W-1:0] FC_NONE    = 2'd0;
  localparam logic [FAIL_CODE_W-1:0] FC_DATA    = 2'd1;
  localparam logic [FAIL_CODE_W-1:0] FC_ADDR    = 2'd2;
  localparam logic [FAIL_CODE_W-1:0] FC_TIMEOUT = 2'd3;

endpackage

// File: rtl/exp_table.sv
// Expected-write table: N_EXP (address, data) pairs, one write port,
// one asynchronous read port. Cleared to zero on reset.
//   clk, reset    : clock, async active-low reset
//   we/widx       : write strobe and entry index (indices >= N_EXP ignored)
//   waddr/wdata   : entry contents to store
//   ridx          : read index
//   raddr/rdata   : entry contents at ridx (zero when ridx is out of range)
module exp_table #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned N_EXP  = 4,
  parameter int unsigned IDX_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [IDX_W-1:0]  widx,
  input  logic [DATA_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [IDX_W-1:0]  ridx,
  output logic [DATA_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] N_EXP_C = CNT_W'(N_EXP);

  logic [DATA_W-1:0] addr_mem [N_EXP];
  logic [DATA_W-1:0] data_mem [N_EXP];

  logic widx_ok;
  logic ridx_ok;

  assign widx_ok = ({1'b0, widx} < N_EXP_C);
  assign ridx_ok = ({1'b0, ridx} < N_EXP_C);

  // Storage with whole-table clear on reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(N_EXP); i++) begin
        addr_mem[i] <= '0;
        data_mem[i] <= '0;
      end
    end else if (we && widx_ok) begin
      addr_mem[widx] <= waddr;
      data_mem[widx] <= wdata;
    end
  end

  assign raddr = ridx_ok ? addr_mem[ridx] : '0;
  assign rdata = ridx_ok ? data_mem[ridx] : '0;

endmodule

// File: rtl/mem_write_checker.sv
// On-chip monitor for the core data-memory write port. Compares the write
// stream against a programmed list of expected (address, data) writes and
// reports sticky pass/fail with diagnostics.
//   clk, reset             : clock, async active-low reset
//   cfg_we/cfg_idx/...     : expected-table load (ignored while running)
//   num_exp, timeout       : run parameters, sampled on start
//   start                  : launch a fresh run from IDLE/PASS/FAIL
//   mem_write/addr/wdata   : observed core write port
//   busy/done/pass/fail    : run status
//   fail_code/addr/data    : failure diagnostics
//   match_cnt, cycle_cnt   : progress counters
module mem_write_checker
  import mem_chk_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned N_EXP     = 4,
  parameter int unsigned IDX_W     = (N_EXP == 1) ? 1 : $clog2(N_EXP),
  parameter int unsigned TIMEOUT_W = 16,
  parameter bit          STRICT    = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_we,
  input  logic [IDX_W-1:0]       cfg_idx,
  input  logic [DATA_W-1:0]      cfg_addr,
  input  logic [DATA_W-1:0]      cfg_data,
  input  logic [IDX_W:0]         num_exp,
  input  logic [TIMEOUT_W-1:0]   timeout,
  input  logic                   start,
  input  logic                   mem_write,
  input  logic [DATA_W-1:0]      mem_addr,
  input  logic [DATA_W-1:0]      mem_wdata,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic                   fail,
  output logic [FAIL_CODE_W-1:0] fail_code,
  output logic [DATA_W-1:0]      fail_addr,
  output logic [DATA_W-1:0]      fail_data,
  output logic [IDX_W:0]         match_cnt,
  output logic [TIMEOUT_W-1:0]   cycle_cnt
);

  localparam int unsigned CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] N_EXP_C = CNT_W'(N_EXP);

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0]       num_q, num_d;
  logic [TIMEOUT_W-1:0]   tmo_q, tmo_d;
  logic [CNT_W-1:0]       match_d;
  logic [TIMEOUT_W-1:0]   cycle_d;
  logic [FAIL_CODE_W-1:0] fcode_d;
  logic [DATA_W-1:0]      faddr_d, fdata_d;
  logic                   term_c;

  logic                   tbl_we;
  logic [DATA_W-1:0]      exp_addr, exp_data;

  assign tbl_we = cfg_we && (state_q != ST_RUN);

  exp_table #(
    .DATA_W (DATA_W),
    .N_EXP  (N_EXP),
    .IDX_W  (IDX_W)
  ) u_exp_table (
    .clk   (clk),
    .reset (reset),
    .we    (tbl_we),
    .widx  (cfg_idx),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .ridx  (ptr_q),
    .raddr (exp_addr),
    .rdata (exp_data)
  );

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    num_d   = num_q;
    tmo_d   = tmo_q;
    match_d = match_cnt;
    cycle_d = cycle_cnt;
    fcode_d = fail_code;
    faddr_d = fail_addr;
    fdata_d = fail_data;
    term_c  = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_PASS, ST_FAIL: begin
        if (start) begin
          state_d = ST_RUN;
          // Zero or oversized counts run against the full table
          num_d   = ((num_exp == '0) || (num_exp > N_EXP_C)) ? N_EXP_C : num_exp;
          tmo_d   = timeout;
          ptr_d   = '0;
          match_d = '0;
          cycle_d = '0;
          fcode_d = FC_NONE;
          faddr_d = '0;
          fdata_d = '0;
        end
      end

      ST_RUN: begin
        cycle_d = (cycle_cnt == {TIMEOUT_W{1'b1}}) ? cycle_cnt
                                                   : cycle_cnt + TIMEOUT_W'(1);
        if (mem_write) begin
          if (mem_addr == exp_addr) begin
            if (mem_wdata == exp_data) begin
              ptr_d   = ptr_q + IDX_W'(1);
              match_d = match_cnt + CNT_W'(1);
              if (match_d == num_q) begin
                state_d = ST_PASS;
                term_c  = 1'b1;
              end
            end else begin
              state_d = ST_FAIL;
              fcode_d = FC_DATA;
              faddr_d = mem_addr;
              fdata_d = mem_wdata;
              term_c  = 1'b1;
            end
          end else if (STRICT) begin
            state_d = ST_FAIL;
            fcode_d = FC_ADDR;
            faddr_d = mem_addr;
            fdata_d = mem_wdata;
            term_c  = 1'b1;
          end
        end
        // A terminating write on the same cycle wins over the timeout
        if (!term_c && (tmo_q != '0) &&
            (TIMEOUT_W'(cycle_cnt + TIMEOUT_W'(1)) == tmo_q)) begin
          state_d = ST_FAIL;
          fcode_d = FC_TIMEOUT;
          faddr_d = '0;
          fdata_d = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      num_q     <= '0;
      tmo_q     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_code <= FC_NONE;
      fail_addr <= '0;
      fail_data <= '0;
      match_cnt <= '0;
      cycle_cnt <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      num_q     <= num_d;
      tmo_q     <= tmo_d;
      busy      <= (state_d == ST_RUN);
      done      <= (state_d == ST_PASS) || (state_d == ST_FAIL);
      pass      <= (state_d == ST_PASS);
      fail      <= (state_d == ST_FAIL);
      fail_code <= fcode_d;
      fail_addr <= faddr_d;
      fail_data <= fdata_d;
      match_cnt <= match_d;
      cycle_cnt <= cycle_d;
    end
  end

endmodule

// File: tb/tb_mem_write_checker.sv
// Directed bench for mem_write_checker: a lenient (STRICT=0) and a strict
// (STRICT=1) instance share one stimulus stream.
module tb_mem_write_checker;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned N_EXP     = 4;
  localparam int unsigned IDX_W     = 2;
  localparam int unsigned TIMEOUT_W = 16;

  logic                 clk;
  logic                 reset;
  logic                 cfg_we;
  logic [IDX_W-1:0]     cfg_idx;
  logic [DATA_W-1:0]    cfg_addr;
  logic [DATA_W-1:0]    cfg_data;
  logic [IDX_W:0]       num_exp;
  logic [TIMEOUT_W-1:0] timeout;
  logic                 start;
  logic                 mem_write;
  logic [DATA_W-1:0]    mem_addr;
  logic [DATA_W-1:0]    mem_wdata;

  logic                 busy0, done0, pass0, fail0;
  logic [1:0]           fc0;
  logic [DATA_W-1:0]    fa0, fd0;
  logic [IDX_W:0]       mc0;
  logic [TIMEOUT_W-1:0] cc0;

  logic                 busy1, done1, pass1, fail1;
  logic [1:0]           fc1;
  logic [DATA_W-1:0]    fa1, fd1;
  logic [IDX_W:0]       mc1;
  logic [TIMEOUT_W-1:0] cc1;

  logic [7:0]           st0, st1;
  assign st0 = {busy0, pass0, fail0, fc0, mc0};
  assign st1 = {busy1, pass1, fail1, fc1, mc1};

  int checks   = 0;
  int failures = 0;

  mem_write_checker #(
    .DATA_W(DATA_W), .N_EXP(N_EXP), .IDX_W(IDX_W), .TIMEOUT_W(TIMEOUT_W), .STRICT(1'b0)
  ) dut0 (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .num_exp(num_exp), .timeout(timeout), .start(start),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy0), .done(done0), .pass(pass0), .fail(fail0), .fail_code(fc0),
    .fail_addr(fa0), .fail_data(fd0), .match_cnt(mc0), .cycle_cnt(cc0)
  );

  mem_write_checker #(
    .DATA_W(DATA_W), .N_EXP(N_EXP), .IDX_W(IDX_W), .TIMEOUT_W(TIMEOUT_W), .STRICT(1'b1)
  ) dut1 (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .num_exp(num_exp), .timeout(timeout), .start(start),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy1), .done(done1), .pass(pass1), .fail(fail1), .fail_code(fc1),
    .fail_addr(fa1), .fail_data(fd1), .match_cnt(mc1), .cycle_cnt(cc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [2:0]  n;
    logic        wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [7:0]  e0;
    logic [7:0]  e1;
  } vec_t;

  vec_t vecs [22];

  // Status word: {busy, pass, fail, fail_code, match_cnt}
  function automatic logic [7:0] stv(input logic b, input logic p, input logic f,
                                     input logic [1:0] c, input logic [2:0] m);
    return {b, p, f, c, m};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] idx, input logic [31:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_idx = idx; cfg_addr = a; cfg_data = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic run(input logic [2:0] n, input logic [15:0] tmo);
    start = 1'b1; num_exp = n; timeout = tmo;
    tick();
    start = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    mem_write = 1'b1; mem_addr = a; mem_wdata = d;
    tick();
    mem_write = 1'b0;
  endtask

  initial begin
    reset = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_addr = '0; cfg_data = '0;
    num_exp = '0; timeout = '0; start = 1'b0; mem_write = 1'b0;
    mem_addr = '0; mem_wdata = '0;

    vecs[0]  = '{1'b1, 3'd2, 1'b0, 32'd0,   32'd0, stv(1,0,0,0,0), stv(1,0,0,0,0)};
    vecs[1]  = '{1'b0, 3'd0, 1'b1, 32'd96,  32'd7, stv(1,0,0,0,1), stv(1,0,0,0,1)};
    vecs[2]  = '{1'b0, 3'd0, 1'b0, 32'd0,   32'd0, stv(1,0,0,0,1), stv(1,0,0,0,1)};
    vecs[3]  = '{1'b0, 3'd0, 1'b1, 32'd100, 32'd7, stv(0,1,0,0,2), stv(0,1,0,0,2)};
    vecs[4]  = '{1'b0, 3'd0, 1'b0, 32'd0,   32'd0, stv(0,1,0,0,2), stv(0,1,0,0,2)};
    vecs[5]  = '{1'b1, 3'd2, 1'b0, 32'd0,   32'd0, stv(1,0,0,0,0), stv(1,0,0,0,0)};
    vecs[6]  = '{1'b0, 3'd0, 1'b1, 32'd200, 32'd5, stv(1,0,0,0,0), stv(0,0,1,2,0)};
    vecs[7]  = '{1'b0, 3'd0, 1'b1, 32'd96,  32'd7, stv(1,0,0,0,1), stv(0,0,1,2,0)};
    vecs[8]  = '{1'b0, 3'd0, 1'b1, 32'd100, 32'd8, stv(0,0,1,1,1), stv(0,0,1,2,0)};
    vecs[9]  = '{1'b1, 3'd0, 1'b0, 32'd0,   32'd0, stv(1,0,0,0,0), stv(1,0,0,0,0)};
    vecs[10] = '{1'b0, 3'd0, 1'b1, 32'd96,  32'd7, stv(1,0,0,0,1), stv(1,0,0,0,1)};
    vecs[11] = '{1'b0, 3'd0, 1'b1, 32'd100, 32'd7, stv(1,0,0,0,2), stv(1,0,0,0,2)};
    vecs[12] = '{1'b0, 3'd0, 1'b1, 32'd104, 32'd9, stv(1,0,0,0,3), stv(1,0,0,0,3)};
    vecs[13] = '{1'b0, 3'd0, 1'b1, 32'd108, 32'd1, stv(0,1,0,0,4), stv(0,1,0,0,4)};
    vecs[14] = '{1'b1, 3'd7, 1'b0, 32'd0,   32'd0, stv(1,0,0,0,0), stv(1,0,0,0,0)};
    vecs[15] = '{1'b0, 3'd0, 1'b1, 32'd96,  32'd7, stv(1,0,0,0,1), stv(1,0,0,0,1)};
    vecs[16] = '{1'b0, 3'd0, 1'b1, 32'd96,  32'd7, stv(1,0,0,0,1), stv(0,0,1,2,1)};
    vecs[17] = '{1'b1, 3'd1, 1'b1, 32'd100, 32'd7, stv(1,0,0,0,2), stv(1,0,0,0,0)};
    vecs[18] = '{1'b0, 3'd0, 1'b1, 32'd104, 32'd9, stv(1,0,0,0,3), stv(0,0,1,2,0)};
    vecs[19] = '{1'b0, 3'd0, 1'b1, 32'd108, 32'd1, stv(0,1,0,0,4), stv(0,0,1,2,0)};
    vecs[20] = '{1'b1, 3'd1, 1'b1, 32'd96,  32'd7, stv(1,0,0,0,0), stv(1,0,0,0,0)};
    vecs[21] = '{1'b0, 3'd0, 1'b1, 32'd96,  32'd7, stv(0,1,0,0,1), stv(0,1,0,0,1)};

    // Reset state
    #12;
    chk("rst_status0", 64'(st0), 64'd0);
    chk("rst_status1", 64'(st1), 64'd0);
    chk("rst_done0",   64'(done0), 64'd0);
    chk("rst_cycle0",  64'(cc0), 64'd0);
    chk("rst_faddr1",  64'(fa1), 64'd0);
    chk("rst_fdata1",  64'(fd1), 64'd0);
    reset = 1'b1;
    tick();

    load(2'd0, 32'd96, 32'd7);
    load(2'd1, 32'd100, 32'd7);
    load(2'd2, 32'd104, 32'd9);
    load(2'd3, 32'd108, 32'd1);

    // Table-driven single-cycle vectors
    for (int i = 0; i < 22; i++) begin
      start = vecs[i].st; num_exp = vecs[i].n; timeout = '0;
      mem_write = vecs[i].wr; mem_addr = vecs[i].a; mem_wdata = vecs[i].d;
      tick();
      start = 1'b0; mem_write = 1'b0;
      chk($sformatf("vec%0d_lenient", i), 64'(st0), 64'(vecs[i].e0));
      chk($sformatf("vec%0d_strict", i),  64'(st1), 64'(vecs[i].e1));
    end

    // Strict address failure diagnostics; lenient instance skips the stray write
    load(2'd0, 32'd100, 32'd7);
    run(3'd1, 16'd0);
    wr(32'd96, 32'd3);
    chk("addr_status1", 64'(st1), 64'(stv(0,0,1,2,0)));
    chk("addr_faddr1",  64'(fa1), 64'd96);
    chk("addr_fdata1",  64'(fd1), 64'd3);
    chk("addr_done1",   64'(done1), 64'd1);
    chk("addr_status0", 64'(st0), 64'(stv(1,0,0,0,0)));
    wr(32'd100, 32'd7);
    chk("skip_pass0",   64'(st0), 64'(stv(0,1,0,0,1)));
    chk("addr_hold1",   64'(fa1), 64'd96);

    // Data mismatch
    run(3'd1, 16'd0);
    wr(32'd100, 32'd8);
    chk("data_status0", 64'(st0), 64'(stv(0,0,1,1,0)));
    chk("data_fdata0",  64'(fd0), 64'd8);
    chk("data_faddr0",  64'(fa0), 64'd100);
    chk("data_status1", 64'(st1), 64'(stv(0,0,1,1,0)));

    // Timeout with no writes
    run(3'd1, 16'd10);
    repeat (9) tick();
    chk("tmo_busy9",    64'(busy0), 64'd1);
    chk("tmo_cycle9",   64'(cc0), 64'd9);
    tick();
    chk("tmo_status0",  64'(st0), 64'(stv(0,0,1,3,0)));
    chk("tmo_status1",  64'(st1), 64'(stv(0,0,1,3,0)));
    chk("tmo_cycle10",  64'(cc0), 64'd10);
    chk("tmo_faddr0",   64'(fa0), 64'd0);
    chk("tmo_fdata0",   64'(fd0), 64'd0);
    tick();
    chk("tmo_cyclehold", 64'(cc0), 64'd10);

    // Matching write on the timeout cycle wins; table load during RUN ignored
    run(3'd1, 16'd10);
    load(2'd0, 32'd50, 32'd5);
    repeat (8) tick();
    wr(32'd100, 32'd7);
    chk("tmo_win0",     64'(st0), 64'(stv(0,1,0,0,1)));
    chk("tmo_win1",     64'(st1), 64'(stv(0,1,0,0,1)));
    chk("tmo_wincycle", 64'(cc0), 64'd10);

    // Asynchronous reset mid-run after one match
    run(3'd2, 16'd0);
    wr(32'd100, 32'd7);
    chk("pre_rst_match", 64'(mc0), 64'd1);
    reset = 1'b0;
    #2;
    chk("mid_rst_status0", 64'(st0), 64'd0);
    chk("mid_rst_status1", 64'(st1), 64'd0);
    chk("mid_rst_cycle0",  64'(cc0), 64'd0);
    chk("mid_rst_done0",   64'(done0), 64'd0);
    #2;
    reset = 1'b1;

    // Table was cleared: entry0 is now (0,0)
    run(3'd1, 16'd0);
    wr(32'd100, 32'd7);
    chk("clr_ignored0", 64'(st0), 64'(stv(1,0,0,0,0)));
    chk("clr_strict1",  64'(st1), 64'(stv(0,0,1,2,0)));
    wr(32'd0, 32'd0);
    chk("clr_zero0",    64'(st0), 64'(stv(0,1,0,0,1)));

    // Fresh load and run after reset
    load(2'd0, 32'd100, 32'd7);
    run(3'd1, 16'd0);
    wr(32'd100, 32'd7);
    chk("reload_pass0", 64'(st0), 64'(stv(0,1,0,0,1)));
    chk("reload_pass1", 64'(st1), 64'(stv(0,1,0,0,1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
